// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser:
// framing byte, command codes, directions, FSM states.
package uart_cmd_parser_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  localparam logic [7:0] CMD_SET_DIR = 8'h01;
  localparam logic [7:0] CMD_START   = 8'h02;
  localparam logic [7:0] CMD_PAUSE   = 8'h03;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_ARG,
    ST_CHK
  } state_t;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte timeout: counts idle cycles while a packet is open,
// pulses expire when the gap reaches TIMEOUT_CYC cycles.
module byte_timeout_timer #(
  parameter int TIMEOUT_CYC = 270833,
  parameter int TO_BITS     = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_BITS-1:0] LAST = TO_BITS'(TIMEOUT_CYC - 1);

  logic [TO_BITS-1:0] cnt_q;
  logic [TO_BITS-1:0] cnt_d;

  // Next count; an arriving byte always beats expiry
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (!enable || clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      expire = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames received UART bytes into A5/CMD/ARG/CHK packets and
// turns valid packets into snake direction/start/pause controls.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYC = 270833,
  parameter int TO_BITS     = 19,
  parameter int ERR_BITS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [1:0]          dir,
  output logic                dir_valid,
  output logic                start_pulse,
  output logic                paused,
  output logic                frame_err,
  output logic [ERR_BITS-1:0] err_cnt
);

  state_t              state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          arg_q, arg_d;
  logic [1:0]          dir_q, dir_d;
  logic                dv_q, dv_d;
  logic                sp_q, sp_d;
  logic                pz_q, pz_d;
  logic                fe_q, fe_d;
  logic [ERR_BITS-1:0] ec_q, ec_d;
  logic                expire;

  byte_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_BITS    (TO_BITS)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (rx_valid),
    .enable(state_q != ST_IDLE),
    .expire(expire)
  );

  // Packet framing, command evaluation and error counting
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    arg_d   = arg_q;
    dir_d   = dir_q;
    pz_d    = pz_q;
    dv_d    = 1'b0;
    sp_d    = 1'b0;
    fe_d    = 1'b0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: if (rx_data == SOF) state_d = ST_CMD;
        ST_CMD: begin
          cmd_d   = rx_data;
          state_d = ST_ARG;
        end
        ST_ARG: begin
          arg_d   = rx_data;
          state_d = ST_CHK;
        end
        default: begin
          state_d = ST_IDLE;
          if (rx_data != (cmd_q ^ arg_q)) begin
            fe_d = 1'b1;
          end else begin
            unique case (1'b1)
              (cmd_q == CMD_SET_DIR): begin
                if (arg_q > 8'd3) begin
                  fe_d = 1'b1;
                end else if (arg_q[1:0] != (dir_q ^ 2'd2) &&
                             arg_q[1:0] != dir_q) begin
                  dir_d = arg_q[1:0];
                  dv_d  = 1'b1;
                end
              end
              (cmd_q == CMD_START): begin
                sp_d = 1'b1;
                pz_d = 1'b0;
              end
              (cmd_q == CMD_PAUSE): begin
                if (arg_q == 8'd0)      pz_d = 1'b0;
                else if (arg_q == 8'd1) pz_d = 1'b1;
                else                    fe_d = 1'b1;
              end
              default: fe_d = 1'b1;
            endcase
          end
        end
      endcase
    end else if (expire) begin
      state_d = ST_IDLE;
      fe_d    = 1'b1;
    end
    ec_d = ec_q;
    if (fe_d && ec_q != '1) ec_d = ec_q + 1'b1;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      arg_q   <= '0;
      dir_q   <= DIR_RIGHT;
      dv_q    <= 1'b0;
      sp_q    <= 1'b0;
      pz_q    <= 1'b0;
      fe_q    <= 1'b0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      dir_q   <= dir_d;
      dv_q    <= dv_d;
      sp_q    <= sp_d;
      pz_q    <= pz_d;
      fe_q    <= fe_d;
      ec_q    <= ec_d;
    end
  end

  assign dir         = dir_q;
  assign dir_valid   = dv_q;
  assign start_pulse = sp_q;
  assign paused      = pz_q;
  assign frame_err   = fe_q;
  assign err_cnt     = ec_q;

endmodule
